// File: rtl/conv1_kernel_fetch.sv
// conv1_kernel_fetch
// Walks a contiguous window of the conv1 weight ROM two words per cycle,
// captures the returned pairs into a 2-entry FIFO and streams them to the
// MAC array over valid/ready. Issue is credit-gated so a registered-read
// ROM result always has a buffer slot waiting for it.
module conv1_kernel_fetch #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16,
    parameter int PAIR_W = 7
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [PAIR_W-1:0] num_pairs,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_addr_a,
    output logic [ADDR_W-1:0] rom_addr_b,
    input  logic [DATA_W-1:0] rom_q_a,
    input  logic [DATA_W-1:0] rom_q_b,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [DATA_W-1:0] w_data0,
    output logic [DATA_W-1:0] w_data1,
    output logic [PAIR_W-1:0] w_index
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t state_reg, state_next;

    // Latched operands and progress counters (one bit wider than num_pairs)
    logic [PAIR_W-1:0] num_reg;
    logic [PAIR_W:0]   issue_cnt_reg;
    logic [PAIR_W:0]   accept_cnt_reg;

    // Address registers always hold the addresses of the next pair to issue
    logic [ADDR_W-1:0] addr_a_reg;
    logic [ADDR_W-1:0] addr_b_reg;

    // One ROM read may be outstanding; remember its pair index for capture
    logic              inflight_reg;
    logic [PAIR_W-1:0] inflight_idx_reg;

    // 2-entry output FIFO
    logic [DATA_W-1:0] buf_d0_reg  [2];
    logic [DATA_W-1:0] buf_d1_reg  [2];
    logic [PAIR_W-1:0] buf_idx_reg [2];
    logic              wr_ptr_reg;
    logic              rd_ptr_reg;
    logic [1:0]        count_reg;

    logic       start_take;
    logic       xfer;
    logic       capture;
    logic       last_issue;
    logic       final_xfer;
    logic       issue;
    logic [2:0] credits_used;

    assign start_take = (state_reg == ST_IDLE) && start;
    assign xfer       = w_valid && w_ready;
    assign capture    = inflight_reg;
    assign last_issue = (issue_cnt_reg == {1'b0, num_reg});
    assign final_xfer = xfer && ((accept_cnt_reg + (PAIR_W+1)'(1)) == {1'b0, num_reg});

    // Slots committed at the next edge: buffered + in flight, less the pair
    // leaving this cycle. Keeping this below 2 guarantees the read issued now
    // finds a free slot when it returns, while still allowing one pair per
    // cycle under continuous w_ready.
    assign credits_used = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, xfer};
    assign issue        = (state_reg == ST_FETCH) && !last_issue && (credits_used < 3'd2);

    // Sequencer state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = (num_pairs == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (last_issue) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (final_xfer) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Operand latch, address walk and issue/accept counters
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            num_reg          <= '0;
            addr_a_reg       <= '0;
            addr_b_reg       <= '0;
            issue_cnt_reg    <= '0;
            accept_cnt_reg   <= '0;
            inflight_reg     <= 1'b0;
            inflight_idx_reg <= '0;
        end else begin
            inflight_reg <= issue;
            if (start_take) begin
                num_reg        <= num_pairs;
                issue_cnt_reg  <= '0;
                accept_cnt_reg <= '0;
                if (num_pairs != '0) begin
                    addr_a_reg <= base_addr;
                    addr_b_reg <= base_addr + ADDR_W'(1);
                end
            end else begin
                if (issue) begin
                    addr_a_reg       <= addr_a_reg + ADDR_W'(2);
                    addr_b_reg       <= addr_b_reg + ADDR_W'(2);
                    issue_cnt_reg    <= issue_cnt_reg + (PAIR_W+1)'(1);
                    inflight_idx_reg <= issue_cnt_reg[PAIR_W-1:0];
                end
                if (xfer) begin
                    accept_cnt_reg <= accept_cnt_reg + (PAIR_W+1)'(1);
                end
            end
        end
    end

    // FIFO storage: each entry written when the write pointer selects it
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_buf
            // Capture the returning ROM pair into entry gi
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    buf_d0_reg[gi]  <= '0;
                    buf_d1_reg[gi]  <= '0;
                    buf_idx_reg[gi] <= '0;
                end else if (capture && (wr_ptr_reg == 1'(gi))) begin
                    buf_d0_reg[gi]  <= rom_q_a;
                    buf_d1_reg[gi]  <= rom_q_b;
                    buf_idx_reg[gi] <= inflight_idx_reg;
                end
            end
        end
    endgenerate

    // FIFO pointers and occupancy
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (capture) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (xfer) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_reg + {1'b0, capture} - {1'b0, xfer};
        end
    end

    assign busy       = (state_reg == ST_FETCH) || (state_reg == ST_DRAIN);
    assign done       = (state_reg == ST_DONE);
    assign rom_addr_a = addr_a_reg;
    assign rom_addr_b = addr_b_reg;
    assign w_valid    = (count_reg != 2'd0);
    assign w_data0    = buf_d0_reg[rd_ptr_reg];
    assign w_data1    = buf_d1_reg[rd_ptr_reg];
    assign w_index    = buf_idx_reg[rd_ptr_reg];

endmodule

// File: tb/tb_conv1_kernel_fetch.sv
// Testbench for conv1_kernel_fetch: behavioural 1-cycle ROM, expected pairs
// queued at start and popped as the DUT hands them over.
module tb_conv1_kernel_fetch;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [6:0]  base_addr;
    logic [6:0]  num_pairs;
    logic        busy;
    logic        done;
    logic [6:0]  rom_addr_a;
    logic [6:0]  rom_addr_b;
    logic [15:0] rom_q_a;
    logic [15:0] rom_q_b;
    logic        w_valid;
    logic        w_ready;
    logic [15:0] w_data0;
    logic [15:0] w_data1;
    logic [6:0]  w_index;

    typedef struct packed {
        logic [15:0] d0;
        logic [15:0] d1;
        logic [6:0]  idx;
    } pair_t;

    pair_t       exp_q[$];
    logic [15:0] rom [128];
    int          total;
    int          bad;

    conv1_kernel_fetch #(.ADDR_W(7), .DATA_W(16), .PAIR_W(7)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .base_addr  (base_addr),
        .num_pairs  (num_pairs),
        .busy       (busy),
        .done       (done),
        .rom_addr_a (rom_addr_a),
        .rom_addr_b (rom_addr_b),
        .rom_q_a    (rom_q_a),
        .rom_q_b    (rom_q_b),
        .w_valid    (w_valid),
        .w_ready    (w_ready),
        .w_data0    (w_data0),
        .w_data1    (w_data1),
        .w_index    (w_index)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ROM: registered read, 1-cycle latency
    always @(posedge clock) begin
        rom_q_a <= rom[rom_addr_a];
        rom_q_b <= rom[rom_addr_b];
    end

    function automatic pair_t exp_pair(input int base, input int k);
        pair_t p;
        p.d0  = rom[(base + 2*k) % 128];
        p.d1  = rom[(base + 2*k + 1) % 128];
        p.idx = 7'(k);
        return p;
    endfunction

    // Runs one fetch. mode 0: w_ready held high; mode 1: random w_ready.
    // restart_at >= 0 pulses a second start (other base) in that cycle.
    task automatic run_fetch(input string name, input int base, input int n,
                             input int mode, input int restart_at);
        int    cyc;
        int    last_xfer;
        int    done_cyc;
        int    first_valid;
        logic  stall_prev;
        pair_t held;
        pair_t got;
        pair_t exp;
        logic [6:0] addr_before;

        for (int k = 0; k < n; k++) exp_q.push_back(exp_pair(base, k));
        @(negedge clock);
        addr_before = rom_addr_a;
        start     = 1'b1;
        base_addr = 7'(base);
        num_pairs = 7'(n);
        w_ready   = 1'b1;
        @(negedge clock);
        start       = 1'b0;
        cyc         = 0;
        last_xfer   = -1;
        done_cyc    = -1;
        first_valid = -1;
        stall_prev  = 1'b0;
        held        = '0;
        while (done_cyc < 0 && cyc < 300) begin
            got = {w_data0, w_data1, w_index};
            if (n > 0 && cyc == 0) begin
                total++;
                if ({rom_addr_a, rom_addr_b} !== {7'(base), 7'(base + 1)}) begin
                    bad++;
                    $display("FAIL %s addr0: got a=%0d b=%0d want a=%0d b=%0d", name,
                             rom_addr_a, rom_addr_b, 7'(base), 7'(base + 1));
                end
            end
            if (n > 0 && cyc == 1) begin
                total++;
                if ({rom_addr_a, rom_addr_b} !== {7'(base + 2), 7'(base + 3)}) begin
                    bad++;
                    $display("FAIL %s addr1: got a=%0d b=%0d want a=%0d b=%0d", name,
                             rom_addr_a, rom_addr_b, 7'(base + 2), 7'(base + 3));
                end
            end
            if (n == 0) begin
                total++;
                if (rom_addr_a !== addr_before || w_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL %s no_issue: addr=%0d valid=%b want addr=%0d valid=0",
                             name, rom_addr_a, w_valid, addr_before);
                end
            end
            start = (cyc == restart_at) ? 1'b1 : 1'b0;
            if (cyc == restart_at) begin
                base_addr = 7'(base + 40);
                num_pairs = 7'd3;
            end
            w_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (stall_prev) begin
                total++;
                if (w_valid !== 1'b1 || got !== held) begin
                    bad++;
                    $display("FAIL %s stable: got v=%b %h want v=1 %h", name, w_valid, got, held);
                end
            end
            if (done === 1'b1) begin
                done_cyc = cyc;
                total++;
                if (done_cyc != last_xfer + 1 || busy !== 1'b0 || exp_q.size() != 0) begin
                    bad++;
                    $display("FAIL %s done: cyc=%0d busy=%b left=%0d want cyc=%0d busy=0 left=0",
                             name, done_cyc, busy, exp_q.size(), last_xfer + 1);
                end
            end else begin
                if (n > 0) begin
                    total++;
                    if (busy !== 1'b1) begin
                        bad++;
                        $display("FAIL %s busy: got %b want 1 at cyc %0d", name, busy, cyc);
                    end
                end
                if (w_valid === 1'b1 && first_valid < 0) first_valid = cyc;
                if (w_valid === 1'b1 && w_ready === 1'b1) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL %s extra: got %h want nothing", name, got);
                    end else begin
                        exp = exp_q.pop_front();
                        $display("%s xfer idx=%0d d0=%h d1=%h", name, w_index, w_data0, w_data1);
                        if (got !== exp) begin
                            bad++;
                            $display("FAIL %s pair: got %h want %h", name, got, exp);
                        end
                    end
                    last_xfer = cyc;
                end
            end
            stall_prev = (w_valid === 1'b1) && (w_ready === 1'b0) && (done_cyc < 0);
            held       = got;
            @(negedge clock);
            cyc++;
        end
        start = 1'b0;
        total++;
        if (done_cyc < 0) begin
            bad++;
            $display("FAIL %s timeout: got no done want done", name);
        end
        if (mode == 0 && n > 0 && done_cyc >= 0) begin
            total++;
            if (first_valid != 2 || last_xfer != n + 1) begin
                bad++;
                $display("FAIL %s latency: first=%0d last=%0d want first=2 last=%0d",
                         name, first_valid, last_xfer, n + 1);
            end
        end
        if (n == 0) begin
            total++;
            if (first_valid != -1) begin
                bad++;
                $display("FAIL %s zero_valid: got first=%0d want none", name, first_valid);
            end
        end
        // The pulse must end and nothing (e.g. an ignored start) may follow
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({done, busy, w_valid} !== 3'b000) begin
                bad++;
                $display("FAIL %s after: got done/busy/valid=%b want 000", name, {done, busy, w_valid});
            end
            @(negedge clock);
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        total++;
        if ({busy, done, w_valid, rom_addr_a, rom_addr_b, w_data0, w_data1, w_index} !== '0) begin
            bad++;
            $display("FAIL reset_state: got %b%b%b a=%0d b=%0d %h %h %0d want all 0",
                     busy, done, w_valid, rom_addr_a, rom_addr_b, w_data0, w_data1, w_index);
        end
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_basic();
        run_fetch("basic", 0, 4, 0, -1);
    endtask

    task automatic test_wrap();
        run_fetch("wrap", 126, 2, 0, -1);
    endtask

    task automatic test_backpressure();
        run_fetch("bp", 10, 8, 1, -1);
        run_fetch("bp_long", 60, 20, 1, -1);
    endtask

    task automatic test_zero();
        run_fetch("zero", 33, 0, 0, -1);
    endtask

    task automatic test_restart_ignored();
        run_fetch("restart", 20, 6, 0, 2);
    endtask

    task automatic test_back_to_back();
        run_fetch("b2b_a", 100, 3, 0, -1);
        run_fetch("b2b_b", 5, 5, 1, -1);
    endtask

    task automatic test_reset_mid_fetch();
        int    xfers;
        int    cyc;
        pair_t got;
        pair_t exp;
        @(negedge clock);
        start     = 1'b1;
        base_addr = 7'd0;
        num_pairs = 7'd10;
        w_ready   = 1'b1;
        @(negedge clock);
        start = 1'b0;
        xfers = 0;
        cyc   = 0;
        while (xfers < 3 && cyc < 50) begin
            if (w_valid === 1'b1) begin
                got = {w_data0, w_data1, w_index};
                exp = exp_pair(0, xfers);
                total++;
                if (got !== exp) begin
                    bad++;
                    $display("FAIL midrst pair: got %h want %h", got, exp);
                end
                xfers++;
            end
            @(negedge clock);
            cyc++;
        end
        total++;
        if (xfers < 3) begin
            bad++;
            $display("FAIL midrst timeout: got %0d transfers want 3", xfers);
        end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({busy, done, w_valid, rom_addr_a, rom_addr_b, w_data0, w_data1, w_index} !== '0) begin
            bad++;
            $display("FAIL midrst async: got %b%b%b a=%0d b=%0d %h %h %0d want all 0",
                     busy, done, w_valid, rom_addr_a, rom_addr_b, w_data0, w_data1, w_index);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            total++;
            if ({done, busy, w_valid} !== 3'b000) begin
                bad++;
                $display("FAIL midrst held: got done/busy/valid=%b want 000", {done, busy, w_valid});
            end
        end
        reset_n = 1'b1;
        @(negedge clock);
        total++;
        if ({done, busy, w_valid} !== 3'b000) begin
            bad++;
            $display("FAIL midrst release: got done/busy/valid=%b want 000", {done, busy, w_valid});
        end
        run_fetch("midrst_new", 0, 1, 0, -1);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        start     = 1'b0;
        base_addr = '0;
        num_pairs = '0;
        w_ready   = 1'b0;
        for (int i = 0; i < 128; i++) rom[i] = 16'h1000 + 16'(i);
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero();
        test_restart_ignored();
        test_back_to_back();
        test_reset_mid_fetch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
